pzcorebus_response_select_tracker: RTL and testbench



---
 rtl/pzcorebus_response_select_tracker.sv | 79 +++++++
 tb/tb_pzcorebus_response_select_tracker.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pzcorebus_response_select_tracker.sv
// pzcorebus_response_select_tracker: records the slave of each non-posted command in issue order and presents the oldest as the response select.
// Optional PZCOREBUS_RESPONSE_SELECT_TRACKER_BYPASS_EN forwards a push into an empty FIFO straight to o_select.
module pzcorebus_response_select_tracker #(
  parameter int SLAVES       = 2,
  parameter int SELECT_WIDTH = (SLAVES > 1) ? $clog2(SLAVES) : 1,
  parameter int DEPTH        = 8,
  parameter int COUNT_WIDTH  = $clog2(DEPTH + 1)
)(
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_command_ack,
  input  logic                    i_command_non_posted,
  input  logic [SELECT_WIDTH-1:0] i_command_select,
  output logic                    o_command_enable,
  input  logic                    i_response_ack,
  input  logic                    i_response_last,
  output logic [SELECT_WIDTH-1:0] o_select,
  output logic                    o_select_valid,
  output logic [COUNT_WIDTH-1:0]  o_count,
  output logic                    o_error
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [SELECT_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
  logic [COUNT_WIDTH-1:0]  count_q, count_d;
  logic                    error_q, error_d;
  logic                    empty, full, push, pop, do_push, do_pop, pop_err, push_err;
  assign empty    = wptr_q == rptr_q;
  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign push     = i_command_ack && i_command_non_posted;
  assign pop      = i_response_ack && i_response_last;
  assign push_err = push && full && !pop;
  assign do_pop   = pop && !empty;
`ifdef PZCOREBUS_RESPONSE_SELECT_TRACKER_BYPASS_EN
  logic bypass;
  assign bypass         = empty && push;
  // a bypassed entry retired in the same cycle never touches the FIFO
  assign do_push        = push && !push_err && !(bypass && pop);
  assign pop_err        = pop && empty && !push;
  assign o_select       = bypass ? i_command_select : mem_q[rptr_q[AW-1:0]];
  assign o_select_valid = !empty || push;
`else
  assign do_push        = push && !push_err;
  assign pop_err        = pop && empty;
  assign o_select       = mem_q[rptr_q[AW-1:0]];
  assign o_select_valid = !empty;
`endif
  assign o_command_enable = !full;
  assign o_count          = count_q;
  assign o_error          = error_q;
  always_comb begin
    wptr_d  = do_push ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = do_pop ? rptr_q + PW'(1) : rptr_q;
    count_d = (do_push && !do_pop) ? count_q + COUNT_WIDTH'(1) :
              (do_pop && !do_push) ? count_q - COUNT_WIDTH'(1) : count_q;
    error_d = error_q || pop_err || push_err;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= i_command_select;
    end
  end
endmodule

// File: tb/tb_pzcorebus_response_select_tracker.sv
// tb_pzcorebus_response_select_tracker: directed self-checking bench for the response select tracker.
module tb_pzcorebus_response_select_tracker;
  localparam int SW = 1;
  localparam int CW = 4;
  localparam int DEPTH = 8;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_ack = 1'b0, cmd_np = 1'b0, rsp_ack = 1'b0, rsp_last = 1'b0;
  logic [SW-1:0] cmd_sel = '0;
  logic          cmd_en, sel_valid, err;
  logic [SW-1:0] sel;
  logic [CW-1:0] count;
  logic [SW-1:0] q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  pzcorebus_response_select_tracker dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_command_ack(cmd_ack), .i_command_non_posted(cmd_np), .i_command_select(cmd_sel),
    .o_command_enable(cmd_en),
    .i_response_ack(rsp_ack), .i_response_last(rsp_last),
    .o_select(sel), .o_select_valid(sel_valid), .o_count(count), .o_error(err)
  );
  always #5 clk = ~clk;
  task automatic cycle(input logic ca, input logic np, input logic [SW-1:0] cs, input logic ra, input logic rl);
    cmd_ack = ca; cmd_np = np; cmd_sel = cs; rsp_ack = ra; rsp_last = rl;
    @(posedge clk); #1;
    cmd_ack = 0; cmd_np = 0; cmd_sel = '0; rsp_ack = 0; rsp_last = 0;
  endtask
  task automatic do_reset();
    rst_n = 0; #3;
    q.delete();
    @(posedge clk); #1;
    rst_n = 1;
  endtask
  task automatic test_reset();
    rst_n = 0; #3;
    n_checks++; if (sel !== 1'b0)  begin n_fail++; $display("FAIL reset_select: got %0d exp 0", sel); end
    n_checks++; if (sel_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0d exp 0", sel_valid); end
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d exp 0", count); end
    n_checks++; if (cmd_en !== 1'b1) begin n_fail++; $display("FAIL reset_enable: got %0d exp 1", cmd_en); end
    n_checks++; if (err !== 1'b0)   begin n_fail++; $display("FAIL reset_error: got %0d exp 0", err); end
    @(posedge clk); #1;
    rst_n = 1;
  endtask
  task automatic test_order();
    logic [SW-1:0] pat [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, pat[i], 0, 0);
      n_checks++; if (count !== CW'(i + 1)) begin n_fail++; $display("FAIL order_push_count[%0d]: got %0d exp %0d", i, count, i + 1); end
      n_checks++; if (sel !== 1'b1 || sel_valid !== 1'b1) begin n_fail++; $display("FAIL order_head[%0d]: got sel %0d valid %0d exp 1 1", i, sel, sel_valid); end
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (sel !== pat[i]) begin n_fail++; $display("FAIL order_pop_sel[%0d]: got %0d exp %0d", i, sel, pat[i]); end
      cycle(0, 0, 0, 1, 1);
      n_checks++; if (count !== CW'(2 - i)) begin n_fail++; $display("FAIL order_pop_count[%0d]: got %0d exp %0d", i, count, 2 - i); end
    end
    n_checks++; if (sel_valid !== 1'b0) begin n_fail++; $display("FAIL order_empty_valid: got %0d exp 0", sel_valid); end
  endtask
  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++; if (cmd_en !== 1'b1) begin n_fail++; $display("FAIL full_enable_early[%0d]: got %0d exp 1", i, cmd_en); end
      cycle(1, 1, SW'(i % 2), 0, 0);
      q.push_back(SW'(i % 2));
    end
    n_checks++; if (count !== CW'(DEPTH)) begin n_fail++; $display("FAIL full_count: got %0d exp %0d", count, DEPTH); end
    n_checks++; if (cmd_en !== 1'b0) begin n_fail++; $display("FAIL full_enable: got %0d exp 0", cmd_en); end
    cycle(1, 1, 1'b1, 1, 1);
    void'(q.pop_front()); q.push_back(1'b1);
    n_checks++; if (count !== CW'(DEPTH)) begin n_fail++; $display("FAIL full_pushpop_count: got %0d exp %0d", count, DEPTH); end
    n_checks++; if (sel !== q[0]) begin n_fail++; $display("FAIL full_pushpop_head: got %0d exp %0d", sel, q[0]); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL full_pushpop_error: got %0d exp 0", err); end
    while (q.size() > 0) begin
      n_checks++; if (sel !== q[0]) begin n_fail++; $display("FAIL full_drain_sel: got %0d exp %0d", sel, q[0]); end
      cycle(0, 0, 0, 1, 1);
      void'(q.pop_front());
    end
    n_checks++; if (count !== 4'd0 || cmd_en !== 1'b1) begin n_fail++; $display("FAIL full_drained: got count %0d en %0d exp 0 1", count, cmd_en); end
  endtask
  task automatic test_posted();
    cycle(1, 0, 1'b1, 0, 0);
    n_checks++; if (count !== 4'd0 || sel_valid !== 1'b0) begin n_fail++; $display("FAIL posted_count: got %0d valid %0d exp 0 0", count, sel_valid); end
    cycle(1, 1, 1'b1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 1, 0);
      n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL nonlast_beat[%0d]: got %0d exp 1", i, count); end
    end
    cycle(0, 0, 0, 1, 1);
    n_checks++; if (count !== 4'd0 || err !== 1'b0) begin n_fail++; $display("FAIL last_beat: got count %0d err %0d exp 0 0", count, err); end
  endtask
  task automatic test_wrap();
    for (int k = 0; k < 3; k++) begin
      cycle(1, 1, SW'(k % 2 == 0), 0, 0);
      q.push_back(SW'(k % 2 == 0));
    end
    for (int k = 3; k < 20; k++) begin
      n_checks++; if (sel !== q[0]) begin n_fail++; $display("FAIL wrap_sel[%0d]: got %0d exp %0d", k, sel, q[0]); end
      cycle(1, 1, SW'(k % 2 == 0), 1, 1);
      void'(q.pop_front()); q.push_back(SW'(k % 2 == 0));
      n_checks++; if (count !== 4'd3) begin n_fail++; $display("FAIL wrap_count[%0d]: got %0d exp 3", k, count); end
    end
    while (q.size() > 0) begin
      n_checks++; if (sel !== q[0]) begin n_fail++; $display("FAIL wrap_drain_sel: got %0d exp %0d", sel, q[0]); end
      cycle(0, 0, 0, 1, 1);
      void'(q.pop_front());
    end
    n_checks++; if (count !== 4'd0 || sel_valid !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL wrap_end: got count %0d valid %0d err %0d exp 0 0 0", count, sel_valid, err); end
  endtask
  task automatic test_push_full_error();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1, 1, SW'(i % 2), 0, 0);
      q.push_back(SW'(i % 2));
    end
    cycle(1, 1, 1'b1, 0, 0);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL overflow_error: got %0d exp 1", err); end
    n_checks++; if (count !== CW'(DEPTH) || sel !== q[0]) begin n_fail++; $display("FAIL overflow_state: got count %0d sel %0d exp %0d %0d", count, sel, DEPTH, q[0]); end
  endtask
  task automatic test_pop_empty_error();
    cycle(0, 0, 0, 1, 1);
    n_checks++; if (err !== 1'b1 || count !== 4'd0) begin n_fail++; $display("FAIL underflow: got err %0d count %0d exp 1 0", err, count); end
    cycle(0, 0, 0, 0, 0);
    cycle(1, 1, 1'b1, 0, 0);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL error_sticky: got %0d exp 1", err); end
    rst_n = 0; #3;
    n_checks++; if (err !== 1'b0 || count !== 4'd0) begin n_fail++; $display("FAIL error_cleared: got err %0d count %0d exp 0 0", err, count); end
    @(posedge clk); #1;
    rst_n = 1;
  endtask
  task automatic test_empty_push_pop();
    cmd_ack = 1; cmd_np = 1; cmd_sel = 1'b1; rsp_ack = 1; rsp_last = 1;
    #1;
`ifdef PZCOREBUS_RESPONSE_SELECT_TRACKER_BYPASS_EN
    n_checks++; if (sel !== 1'b1 || sel_valid !== 1'b1) begin n_fail++; $display("FAIL bypass_comb: got sel %0d valid %0d exp 1 1", sel, sel_valid); end
    @(posedge clk); #1;
    cmd_ack = 0; cmd_np = 0; cmd_sel = '0; rsp_ack = 0; rsp_last = 0;
    n_checks++; if (count !== 4'd0 || err !== 1'b0 || sel_valid !== 1'b0) begin n_fail++; $display("FAIL bypass_after: got count %0d err %0d valid %0d exp 0 0 0", count, err, sel_valid); end
`else
    n_checks++; if (sel_valid !== 1'b0) begin n_fail++; $display("FAIL nobypass_comb: got valid %0d exp 0", sel_valid); end
    @(posedge clk); #1;
    cmd_ack = 0; cmd_np = 0; cmd_sel = '0; rsp_ack = 0; rsp_last = 0;
    n_checks++; if (err !== 1'b1 || count !== 4'd1) begin n_fail++; $display("FAIL nobypass_after: got err %0d count %0d exp 1 1", err, count); end
    n_checks++; if (sel !== 1'b1 || sel_valid !== 1'b1) begin n_fail++; $display("FAIL nobypass_head: got sel %0d valid %0d exp 1 1", sel, sel_valid); end
`endif
  endtask
  initial begin
    test_reset();
    test_order();
    test_full();
    test_posted();
    test_wrap();
    test_push_full_error();
    do_reset();
    test_pop_empty_error();
    test_empty_push_pop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
